// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - NREQ-way arbiter for one shared register; define SHARED_REG_ARBITER_RR_EN for round-robin
module shared_reg_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic [7:0]            wr_count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        DONE
    } state_t;

    state_t           state;
    logic [IW-1:0]    winner;
    logic [IW-1:0]    sel_idx;
    logic             sel_found;
    logic [WIDTH-1:0] slice [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            slice[i] = wdata[i*WIDTH +: WIDTH];
        end
    end

`ifdef SHARED_REG_ARBITER_RR_EN
    logic [IW-1:0] ptr;
    logic [IW:0]   cand;

    // Search starts at ptr and wraps; cand is one bit wider so ptr+k never overflows before the wrap.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!sel_found && req[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end
`else
    always_comb begin
        sel_found = |req;
        sel_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                sel_idx = IW'(k);
            end
        end
    end
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            winner   <= '0;
            gnt      <= '0;
            ack      <= '0;
            q        <= '0;
            wr_count <= '0;
`ifdef SHARED_REG_ARBITER_RR_EN
            ptr      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (sel_found) begin
                        winner <= sel_idx;
                        gnt    <= NREQ'(1) << sel_idx;
                        state  <= GRANT;
                    end else begin
                        gnt <= '0;
                    end
                end
                GRANT: begin
                    gnt <= '0;
                    // Only the latched winner's request matters; other requesters cannot disturb it.
                    if (req[winner]) begin
                        q        <= slice[winner];
                        ack      <= NREQ'(1) << winner;
                        wr_count <= wr_count + 8'd1;
`ifdef SHARED_REG_ARBITER_RR_EN
                        ptr      <= (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
`endif
                        state    <= DONE;
                    end else begin
                        ack   <= '0;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - vector table, corner sequences and randomized model check for shared_reg_arbiter
module tb_shared_reg_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  busy;
    logic [7:0]            wr_count;

    int checks   = 0;
    int failures = 0;

    shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .wdata    (wdata),
        .gnt      (gnt),
        .ack      (ack),
        .q        (q),
        .busy     (busy),
        .wr_count (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] wd;
        logic [3:0]  gnt;
        logic [3:0]  ack;
        logic [7:0]  q;
        logic        busy;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs [20];

    // Reference model state: transaction phase 0 idle, 1 granted, 2 write done.
    int         m_phase;
    int         m_win;
    int         m_ptr;
    logic [7:0] m_q;
    int         m_cnt;
    logic [3:0] m_gnt;
    logic [3:0] m_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] r, input logic [31:0] wd);
        reset = rst;
        req   = r;
        wdata = wd;
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
`ifdef SHARED_REG_ARBITER_RR_EN
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (r[k]) return k;
        end
`endif
        return 0;
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] r, input logic [31:0] wd);
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_q = 8'h00; m_cnt = 0; m_gnt = 4'h0; m_ack = 4'h0; m_win = 0;
        end else if (m_phase == 0) begin
            m_ack = 4'h0;
            if (r != 4'h0) begin
                m_win   = pick(r, m_ptr);
                m_gnt   = 4'h1 << m_win;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_gnt = 4'h0;
            if (r[m_win]) begin
                m_q     = wd[m_win*8 +: 8];
                m_ack   = 4'h1 << m_win;
                m_cnt   = (m_cnt + 1) % 256;
                m_ptr   = (m_win + 1) % NREQ;
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end else begin
            m_ack   = 4'h0;
            m_phase = 0;
        end
    endtask

    initial begin
        int         nack;
        int         exp_idx;
        logic       rst;
        logic [3:0] r;
        logic [31:0] wd;

        reset = 1'b1;
        req   = '0;
        wdata = '0;

        vecs[0]  = '{1'b1, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 8'h00, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 4'h4, 32'h00A5_0000, 4'h4, 4'h0, 8'h00, 1'b1, 8'd0};
        vecs[2]  = '{1'b0, 4'h4, 32'h00A5_0000, 4'h0, 4'h4, 8'hA5, 1'b1, 8'd1};
        vecs[3]  = '{1'b0, 4'h4, 32'h00A5_0000, 4'h0, 4'h0, 8'hA5, 1'b0, 8'd1};
        vecs[4]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 8'hA5, 1'b0, 8'd1};
        vecs[5]  = '{1'b1, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 8'h00, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 4'h2, 32'h0000_5500, 4'h2, 4'h0, 8'h00, 1'b1, 8'd0};
        vecs[7]  = '{1'b0, 4'h0, 32'h0000_5500, 4'h0, 4'h0, 8'h00, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 4'h3, 32'h0000_5533, 4'h1, 4'h0, 8'h00, 1'b1, 8'd0};
        vecs[9]  = '{1'b0, 4'h3, 32'h0000_5533, 4'h0, 4'h1, 8'h33, 1'b1, 8'd1};
        vecs[10] = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 8'h33, 1'b0, 8'd1};
        vecs[11] = '{1'b0, 4'h4, 32'h00C3_0000, 4'h4, 4'h0, 8'h33, 1'b1, 8'd1};
        vecs[12] = '{1'b1, 4'h4, 32'h00C3_0000, 4'h0, 4'h0, 8'h00, 1'b0, 8'd0};
        vecs[13] = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 8'h00, 1'b0, 8'd0};
        vecs[14] = '{1'b0, 4'h1, 32'h7700_0011, 4'h1, 4'h0, 8'h00, 1'b1, 8'd0};
        vecs[15] = '{1'b0, 4'h1, 32'h7700_0011, 4'h0, 4'h1, 8'h11, 1'b1, 8'd1};
        vecs[16] = '{1'b0, 4'h8, 32'h7700_0011, 4'h0, 4'h0, 8'h11, 1'b0, 8'd1};
        vecs[17] = '{1'b0, 4'h8, 32'h7700_0011, 4'h8, 4'h0, 8'h11, 1'b1, 8'd1};
        vecs[18] = '{1'b0, 4'h8, 32'h7700_0011, 4'h0, 4'h8, 8'h77, 1'b1, 8'd2};
        vecs[19] = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 8'h77, 1'b0, 8'd2};

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].wd);
            check($sformatf("vec%0d_gnt", i),  32'(gnt),      32'(vecs[i].gnt));
            check($sformatf("vec%0d_ack", i),  32'(ack),      32'(vecs[i].ack));
            check($sformatf("vec%0d_q", i),    32'(q),        32'(vecs[i].q));
            check($sformatf("vec%0d_busy", i), 32'(busy),     32'(vecs[i].busy));
            check($sformatf("vec%0d_cnt", i),  32'(wr_count), 32'(vecs[i].cnt));
        end

        // All four requesters held continuously.
        step(1'b1, 4'h0, 32'h0);
        nack = 0;
        for (int c = 0; c < 15; c++) begin
            step(1'b0, 4'hF, 32'h1312_1110);
            if (ack != 4'h0) begin
                if (nack < 5) begin
`ifdef SHARED_REG_ARBITER_RR_EN
                    exp_idx = nack % 4;
`else
                    exp_idx = 0;
`endif
                    check($sformatf("allreq_ack%0d", nack), 32'(ack), 32'(4'h1 << exp_idx));
                    check($sformatf("allreq_q%0d", nack),   32'(q),   32'(8'h10 + exp_idx));
                end
                nack++;
            end
        end
        check("allreq_ack_count", 32'(nack), 32'd5);

        // wr_count wrap after 256 writes.
        step(1'b1, 4'h0, 32'h0);
        nack = 0;
        for (int c = 0; c < 800 && nack < 256; c++) begin
            step(1'b0, 4'h1, 32'h0000_005A);
            if (ack != 4'h0) begin
                nack++;
                if (nack == 255) check("wrap_cnt255", 32'(wr_count), 32'd255);
            end
        end
        check("wrap_ack_count", 32'(nack), 32'd256);
        check("wrap_cnt0", 32'(wr_count), 32'd0);

        // Randomized traffic against the reference model.
        step(1'b1, 4'h0, 32'h0);
        model_step(1'b1, 4'h0, 32'h0);
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            r   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            wd  = $urandom;
            model_step(rst, r, wd);
            step(rst, r, wd);
            check("rnd_gnt",  32'(gnt),      32'(m_gnt));
            check("rnd_ack",  32'(ack),      32'(m_ack));
            check("rnd_q",    32'(q),        32'(m_q));
            check("rnd_busy", 32'(busy),     32'(m_phase != 0));
            check("rnd_cnt",  32'(wr_count), 32'(m_cnt));
            check("rnd_excl", 32'((gnt != 4'h0) && (ack != 4'h0)), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the shared register data width.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the synchronous, active-high reset.
REQ-005 Port req, input, NREQ, SHALL carry request bit i from requester i.
REQ-006 Port wdata, input, NREQ*WIDTH, SHALL carry requester i data in bits [i*WIDTH +: WIDTH].
REQ-007 Port gnt, output, NREQ, SHALL be a registered one-hot-or-zero grant.
REQ-008 Port ack, output, NREQ, SHALL be a registered one-hot-or-zero write-complete pulse.
REQ-009 Port q, output, WIDTH, SHALL be the shared register value.
REQ-010 Port busy, output, 1, SHALL be high whenever state is not IDLE.
REQ-011 Port wr_count, output, 8, SHALL count completed writes.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, GRANT, DONE.
REQ-013 IDLE with req==0 SHALL stay IDLE; gnt, ack low.
REQ-014 IDLE with any req bit high SHALL select a winner per REQ-021/022, register gnt[winner]=1 and go to GRANT at the next edge.
REQ-015 GRANT with req[winner]==1 SHALL load q with wdata slice of winner, clear gnt, set ack[winner]=1, go to DONE.
REQ-016 GRANT with req[winner]==0 (withdrawal) SHALL clear gnt, leave q and wr_count unchanged, assert no ack, return to IDLE.
REQ-017 DONE SHALL clear ack and return to IDLE unconditionally; requests are ignored in DONE.
REQ-018 Latency SHALL be: req seen at edge N -> gnt high cycle N+1 -> q updated and ack high cycle N+2 -> IDLE cycle N+3; sustained throughput one write per 3 cycles.
REQ-019 Requests changing for non-winners during GRANT/DONE SHALL not affect the current transaction.
REQ-020 wr_count SHALL increment by 1 on each ack, wrapping 255 -> 0.
REQ-021 Priority pointer ptr (index, 0..NREQ-1) SHALL be updated only on a completed write, to (winner+1) mod NREQ; withdrawal SHALL leave ptr unchanged.
REQ-022 Winner SHALL be the first set req bit searching ptr, ptr+1, ... wrapping past NREQ-1 to 0 (see Configuration).
REQ-023 gnt and ack SHALL never be nonzero in the same cycle and each SHALL have at most one bit set.

Reset
REQ-024 reset high at a rising edge SHALL force state IDLE, gnt=0, ack=0, q=0, wr_count=0, ptr=0, overriding any operation in progress.
REQ-025 A transaction interrupted by reset SHALL produce no ack and no q update.
REQ-026 reset SHALL have no effect between clock edges.

Configuration
REQ-027 With macro SHARED_REG_ARBITER_RR_EN defined, winner selection SHALL be round-robin per REQ-021/022.
REQ-028 Without SHARED_REG_ARBITER_RR_EN, winner SHALL be the lowest-index set req bit (fixed priority); ptr SHALL not exist or SHALL be ignored.

Verification
REQ-029 Single requester: reset, req=4'b0100, wdata slice2=8'hA5 -> gnt=4'b0100 cycle 1, q=8'hA5 and ack=4'b0100 cycle 2, busy low cycle 3, wr_count=1.
REQ-030 All requesters held (req=4'b1111, slice i = 8'h10+i), RR_EN defined -> ack order 0,1,2,3,0; q sequence 10,11,12,13,10; without RR_EN -> ack always 4'b0001.
REQ-031 Withdrawal: req=4'b0010, drop req[1] during GRANT -> no ack, q unchanged, wr_count unchanged, next req=4'b0011 with RR_EN grants index 0 (ptr unchanged at 0).
REQ-032 Reset mid-operation: assert reset in GRANT cycle -> next cycle gnt=0, ack=0, q=0, wr_count=0, busy=0.
REQ-033 Wrap: 256 consecutive single-requester writes -> wr_count returns to 0 after the 256th ack.
REQ-034 Late request: req[3] rises during DONE of requester 0 -> ignored until IDLE, then gnt=4'b1000 next cycle.
